// File: rtl/button_debounce_ctrl_if.sv
// ---------------------------------------------------------------------------
// button_debounce_ctrl_if
// Groups the push-button input and the debounced outputs of
// button_debounce_ctrl into one bundle.
//   button        : raw, bouncing, asynchronous button level (1 = pressed)
//   btn_level     : debounced button level
//   press_pulse   : one-cycle strobe per accepted press
//   release_pulse : one-cycle strobe per accepted release
//   long_press    : one-cycle strobe once a press has been held long enough
//   press_count   : 8-bit wrapping count of accepted presses
// master : the side that owns the button (board pin model or bench)
// slave  : the debounce controller
// ---------------------------------------------------------------------------
interface button_debounce_ctrl_if;
  logic       button;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_press;
  logic [7:0] press_count;

  modport master (
    output button,
    input  btn_level, press_pulse, release_pulse, long_press, press_count
  );

  modport slave (
    input  button,
    output btn_level, press_pulse, release_pulse, long_press, press_count
  );
endinterface

// File: rtl/button_debounce_ctrl.sv
// ---------------------------------------------------------------------------
// button_debounce_ctrl
// Debounces a mechanical push button and produces press / release /
// long-press strobes plus a wrapping press counter.
// Ports:
//   clk  : system clock, everything on the rising edge
//   rst  : synchronous active-high reset
//   bus  : button_debounce_ctrl_if.slave (button in, debounced outputs out)
// Parameters:
//   DEBOUNCE_CNT : stable cycles needed to accept a press or a release
//   LONG_CNT     : held cycles, counted from press_pulse, before long_press
// Pipeline: 2-flop synchronizer -> debounce FSM (registered events) ->
// output register stage. The press_pulse latency from the first edge that
// samples button=1 is DEBOUNCE_CNT+3 edges.
// ---------------------------------------------------------------------------
module button_debounce_ctrl #(
  parameter int unsigned DEBOUNCE_CNT = 1000000,
  parameter int unsigned LONG_CNT     = 100000000
) (
  input  logic                  clk,
  input  logic                  rst,
  button_debounce_ctrl_if.slave bus
);

  localparam logic [31:0] DEB_LAST  = 32'(DEBOUNCE_CNT - 1);
  localparam logic [31:0] LONG_LAST = 32'(LONG_CNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  // Synchronizer: the only logic that touches the raw button.
  logic sync1_q, sync2_q;
  logic btn_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.button;
      sync2_q <= sync1_q;
    end
  end

  assign btn_s = sync2_q;

  // Debounce FSM with registered one-cycle event flags.
  state_t      state_q;
  logic [31:0] dcnt_q;
  logic [31:0] hcnt_q;
  logic        long_flag_q;
  logic        press_evt_q;
  logic        release_evt_q;
  logic        long_evt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      dcnt_q        <= '0;
      hcnt_q        <= '0;
      long_flag_q   <= 1'b0;
      press_evt_q   <= 1'b0;
      release_evt_q <= 1'b0;
      long_evt_q    <= 1'b0;
    end else begin
      press_evt_q   <= 1'b0;
      release_evt_q <= 1'b0;
      long_evt_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (btn_s) begin
            state_q <= PRESS_WAIT;
            dcnt_q  <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state_q <= IDLE;                // glitch rejected
          end else if (dcnt_q == DEB_LAST) begin
            state_q     <= PRESSED;
            press_evt_q <= 1'b1;
            hcnt_q      <= '0;
            long_flag_q <= 1'b0;
          end else begin
            dcnt_q <= dcnt_q + 32'd1;
          end
        end
        PRESSED: begin
          if (!btn_s) begin
            state_q <= RELEASE_WAIT;
            dcnt_q  <= '0;
          end else if (!long_flag_q && (hcnt_q == LONG_LAST)) begin
            long_evt_q  <= 1'b1;
            long_flag_q <= 1'b1;            // latches so long_press fires once
          end else if (!long_flag_q) begin
            hcnt_q <= hcnt_q + 32'd1;
          end
        end
        RELEASE_WAIT: begin
          // hcnt and long_flag are left untouched so a release bounce
          // resumes the hold timing instead of restarting it.
          if (btn_s) begin
            state_q <= PRESSED;
          end else if (dcnt_q == DEB_LAST) begin
            state_q       <= IDLE;
            release_evt_q <= 1'b1;
          end else begin
            dcnt_q <= dcnt_q + 32'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output register stage: btn_level and press_count move together with
  // their strobes, so the level never changes without a matching pulse.
  logic       btn_level_q;
  logic       press_pulse_q;
  logic       release_pulse_q;
  logic       long_press_q;
  logic [7:0] press_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_level_q     <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      long_press_q    <= 1'b0;
      press_count_q   <= 8'd0;
    end else begin
      press_pulse_q   <= press_evt_q;
      release_pulse_q <= release_evt_q;
      long_press_q    <= long_evt_q;
      if (press_evt_q) begin
        btn_level_q   <= 1'b1;
        press_count_q <= press_count_q + 8'd1;   // wraps 255 -> 0
      end else if (release_evt_q) begin
        btn_level_q <= 1'b0;
      end
    end
  end

  assign bus.btn_level     = btn_level_q;
  assign bus.press_pulse   = press_pulse_q;
  assign bus.release_pulse = release_pulse_q;
  assign bus.long_press    = long_press_q;
  assign bus.press_count   = press_count_q;

endmodule

// File: tb/tb_button_debounce_ctrl.sv
// ---------------------------------------------------------------------------
// tb_button_debounce_ctrl
// Directed bench for button_debounce_ctrl with DEBOUNCE_CNT=4, LONG_CNT=16.
// Edge k of a section is the k-th rising edge after the section's first
// input change; outputs are sampled 1 time unit after each edge.
// ---------------------------------------------------------------------------
module tb_button_debounce_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   failed = 0;
  int   npress = 0;

  always #5 clk = ~clk;

  button_debounce_ctrl_if bus();

  button_debounce_ctrl #(
    .DEBOUNCE_CNT (4),
    .LONG_CNT     (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    bus.button = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    bus.button = 1'b0;

    // Reset state
    do_reset();
    chk("rst_btn_level", 32'(bus.btn_level), 0);
    chk("rst_press_pulse", 32'(bus.press_pulse), 0);
    chk("rst_release_pulse", 32'(bus.release_pulse), 0);
    chk("rst_long_press", 32'(bus.long_press), 0);
    chk("rst_press_count", 32'(bus.press_count), 0);
    $display("[TB] reset state checked");

    // Clean press and clean release
    do_reset();
    bus.button = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk($sformatf("clean_press_pulse k=%0d", k), 32'(bus.press_pulse), 32'(k == 7));
      chk($sformatf("clean_level k=%0d", k), 32'(bus.btn_level), 32'(k >= 7));
      chk($sformatf("clean_rel_pulse k=%0d", k), 32'(bus.release_pulse), 0);
      chk($sformatf("clean_long k=%0d", k), 32'(bus.long_press), 0);
    end
    chk("clean_press_count", 32'(bus.press_count), 1);
    bus.button = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk($sformatf("clean_release_pulse k=%0d", k), 32'(bus.release_pulse), 32'(k == 7));
      chk($sformatf("clean_release_level k=%0d", k), 32'(bus.btn_level), 32'(k < 7));
      chk($sformatf("clean_release_press k=%0d", k), 32'(bus.press_pulse), 0);
    end
    $display("[TB] clean press/release checked");

    // Glitch rejection: 3 high cycles
    do_reset();
    for (int k = 0; k < 12; k++) begin
      bus.button = (k < 3);
      cyc();
      chk($sformatf("glitch_press k=%0d", k), 32'(bus.press_pulse), 0);
      chk($sformatf("glitch_level k=%0d", k), 32'(bus.btn_level), 0);
    end
    chk("glitch_press_count", 32'(bus.press_count), 0);
    $display("[TB] glitch rejection checked");

    // Long press: held 40 cycles, then released
    do_reset();
    for (int k = 0; k < 56; k++) begin
      bus.button = (k < 40);
      cyc();
      chk($sformatf("long_press_pulse k=%0d", k), 32'(bus.press_pulse), 32'(k == 7));
      chk($sformatf("long_long k=%0d", k), 32'(bus.long_press), 32'(k == 23));
      chk($sformatf("long_release k=%0d", k), 32'(bus.release_pulse), 32'(k == 47));
      chk($sformatf("long_level k=%0d", k), 32'(bus.btn_level), 32'(k >= 7 && k < 47));
    end
    $display("[TB] long press checked");

    // Release bounce: low for 2 cycles while pressed; long_press delayed 3
    do_reset();
    for (int k = 0; k < 31; k++) begin
      bus.button = !(k == 15 || k == 16);
      cyc();
      chk($sformatf("bounce_press k=%0d", k), 32'(bus.press_pulse), 32'(k == 7));
      chk($sformatf("bounce_release k=%0d", k), 32'(bus.release_pulse), 0);
      chk($sformatf("bounce_level k=%0d", k), 32'(bus.btn_level), 32'(k >= 7));
      chk($sformatf("bounce_long k=%0d", k), 32'(bus.long_press), 32'(k == 26));
    end
    chk("bounce_press_count", 32'(bus.press_count), 1);
    $display("[TB] release bounce checked");

    // Counter wrap: 256 clean presses
    do_reset();
    npress = 0;
    for (int p = 0; p < 256; p++) begin
      bus.button = 1'b1;
      for (int k = 0; k < 10; k++) begin
        cyc();
        if (bus.press_pulse === 1'b1) npress++;
      end
      bus.button = 1'b0;
      for (int k = 0; k < 10; k++) begin
        cyc();
        if (bus.press_pulse === 1'b1) npress++;
      end
      if (p == 254) chk("wrap_count_255", 32'(bus.press_count), 255);
    end
    chk("wrap_pulses_seen", 32'(npress), 256);
    chk("wrap_count_0", 32'(bus.press_count), 0);
    $display("[TB] press counter wrap checked");

    // Reset in the cycle press_pulse is due
    bus.button = 1'b1;
    for (int k = 0; k < 7; k++) begin
      cyc();
      chk($sformatf("due_pre_press k=%0d", k), 32'(bus.press_pulse), 0);
    end
    rst = 1'b1;
    cyc();
    chk("due_press_pulse", 32'(bus.press_pulse), 0);
    chk("due_btn_level", 32'(bus.btn_level), 0);
    chk("due_press_count", 32'(bus.press_count), 0);
    chk("due_release_pulse", 32'(bus.release_pulse), 0);
    chk("due_long_press", 32'(bus.long_press), 0);
    rst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      cyc();
      chk($sformatf("after_rst_press j=%0d", j), 32'(bus.press_pulse), 32'(j == 7));
    end
    chk("after_rst_count", 32'(bus.press_count), 1);
    $display("[TB] reset-over-strobe checked");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/button_debounce_ctrl.md
BUTTON_DEBOUNCE_CTRL -- requirements
Module: button_debounce_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CNT, default 1000000, is the number of stable cycles needed to accept a press or release (10 ms at 100 MHz); legal range 2..2^32-1.
REQ-002 Parameter LONG_CNT, default 100000000, is the number of debounced-pressed cycles, counted from press_pulse, before long_press fires (1 s at 100 MHz); legal range 2..2^32-1.
REQ-003 clk  input  1  the single system clock; all logic is on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 button  input  1  raw asynchronous, bouncing push-button level, where 1 means pressed.
REQ-006 btn_level  output  1  debounced button level.
REQ-007 press_pulse  output  1  one-cycle strobe on each accepted press; this is the start request for the light controller.
REQ-008 release_pulse  output  1  one-cycle strobe on each accepted release.
REQ-009 long_press  output  1  one-cycle strobe when a press has been held for LONG_CNT cycles.
REQ-010 press_count  output  8  running count of accepted presses.

Function
REQ-011 button shall pass through a 2-flop synchronizer to give btn_s; no other logic shall sample button directly.
REQ-012 The FSM shall have four states, IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus a 32-bit debounce counter dcnt, a 32-bit hold counter hcnt and a long_flag register.
REQ-013 IDLE: if btn_s=1, go to PRESS_WAIT with dcnt<=0; otherwise stay in IDLE.
REQ-014 PRESS_WAIT, when btn_s=0: return to IDLE with no output (glitch rejected).
REQ-015 PRESS_WAIT, when btn_s=1 and dcnt=DEBOUNCE_CNT-1: go to PRESSED, pulse press_pulse, set btn_level<=1, increment press_count, and clear hcnt<=0 and long_flag<=0.
REQ-016 PRESS_WAIT, otherwise: dcnt<=dcnt+1.
REQ-017 PRESSED, when btn_s=0: go to RELEASE_WAIT with dcnt<=0.
REQ-018 PRESSED, when btn_s=1, long_flag=0 and hcnt=LONG_CNT-1: pulse long_press, set long_flag<=1, stay in PRESSED.
REQ-019 PRESSED, otherwise: if long_flag=0, hcnt<=hcnt+1; hcnt shall never advance once long_flag=1.
REQ-020 RELEASE_WAIT, when btn_s=1: return to PRESSED with no output; hcnt and long_flag are kept (bounce tolerated).
REQ-021 RELEASE_WAIT, when btn_s=0 and dcnt=DEBOUNCE_CNT-1: go to IDLE, pulse release_pulse, set btn_level<=0.
REQ-022 RELEASE_WAIT, otherwise: dcnt<=dcnt+1; hcnt is frozen.
REQ-023 All outputs shall be registered; no output shall be a combinational function of button or btn_s.
REQ-024 Latency: press_pulse shall assert exactly DEBOUNCE_CNT+3 rising edges after the first edge that samples button=1, given button stays high.
REQ-025 long_press shall assert exactly LONG_CNT cycles after press_pulse when btn_s stays 1 throughout; cycles spent in RELEASE_WAIT extend this by their duration.
REQ-026 long_press shall fire at most once per accepted press.
REQ-027 Each strobe (press_pulse, release_pulse, long_press) shall be high for exactly one cycle.
REQ-028 press_pulse and release_pulse shall never be high in the same cycle.
REQ-029 press_count shall wrap from 255 to 0 without saturating or flagging.
REQ-030 btn_level shall change only in the same cycle as press_pulse or release_pulse.

Reset
REQ-031 While rst=1 at a clock edge, the block shall load state IDLE, synchronizer flops 0, dcnt 0, hcnt 0, long_flag 0, btn_level 0, all strobes 0 and press_count 0.
REQ-032 rst shall take priority over every transition, including a strobe due in the same cycle; that strobe shall not appear.
REQ-033 Reset asserted mid-operation in any state shall abort the operation; after rst falls, a still-held button shall be treated as a new press needing the full debounce.

Verification (bench parameters DEBOUNCE_CNT=4, LONG_CNT=16)
REQ-034 Clean press: rst pulsed, then button=1 held from edge 0 -> press_pulse high only in the cycle after edge 7; btn_level=1 from then; press_count=1.
REQ-035 Glitch rejection: button high for 3 cycles, then low -> no press_pulse, btn_level stays 0, press_count stays 0.
REQ-036 Long press: button held 40 cycles -> press_pulse after edge 7; long_press after edge 23; no second long_press; release then gives release_pulse 7 edges after button falls.
REQ-037 Release bounce: while pressed, button low for 2 cycles, then high -> no release_pulse, btn_level stays 1, no extra press_pulse.
REQ-038 Wrap and reset: 256 clean presses -> press_count=0; then rst asserted in the cycle press_pulse is due -> no press_pulse, all outputs 0.
